activation_unit: RTL and testbench

Streaming element-wise activation stage directly downstream of the batch normalization unit. It consumes the normalized Q8.8 feature-map stream channel by channel and applies one of four activations: ReLU, ReLU6, leaky ReLU or identity. It emits the result with valid/ready backpressure, tags each element with channel index and last flag, and counts zeros produced for sparsity reporting. One output register stage gives 1-cycle latency at full throughput.

---
 rtl/activation_pkg.sv | 21 ++
 rtl/activation_func.sv | 39 +++
 rtl/activation_unit.sv | 142 ++++++++++++++
 tb/tb_activation_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/activation_pkg.sv
// rtl/activation_pkg.sv - shared encodings and constants for the activation stage
package activation_pkg;

    localparam int Q_FRAC = 8;
    localparam logic [15:0] RELU6_MAX = 16'(6 << Q_FRAC);

    typedef enum logic [1:0] {
        ACT_RELU     = 2'b00,
        ACT_RELU6    = 2'b01,
        ACT_LEAKY    = 2'b10,
        ACT_IDENTITY = 2'b11
    } act_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } act_state_t;

endpackage

// File: rtl/activation_func.sv
// rtl/activation_func.sv - combinational element-wise activation of one Q8.8 sample
module activation_func
    import activation_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] x,
    input  act_mode_t             mode,
    input  logic [3:0]            leaky_shift,
    output logic [DATA_WIDTH-1:0] y
);

    logic signed [DATA_WIDTH-1:0] x_s;
    logic signed [DATA_WIDTH-1:0] max_s;
    logic                         neg;

    assign x_s   = x;
    assign max_s = DATA_WIDTH'(RELU6_MAX);
    assign neg   = x_s[DATA_WIDTH-1];

    // Select the activation; leaky uses an arithmetic shift so small negatives stay at -1
    always_comb begin
        y = x;
        case (mode)
            ACT_RELU: begin
                if (neg) y = '0;
            end
            ACT_RELU6: begin
                if (neg)             y = '0;
                else if (x_s > max_s) y = max_s;
            end
            ACT_LEAKY: begin
                if (neg) y = x_s >>> leaky_shift;
            end
            default: y = x;
        endcase
    end

endmodule

// File: rtl/activation_unit.sv
// rtl/activation_unit.sv - streaming activation stage with run control and zero counting
module activation_unit
    import activation_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  clear,
    input  logic [1:0]            mode,
    input  logic [3:0]            leaky_shift,
    input  logic [15:0]           num_channels,
    input  logic [15:0]           feature_size,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           zero_count,
    input  logic [DATA_WIDTH-1:0] input_data,
    input  logic                  input_valid,
    output logic                  input_ready,
    output logic [DATA_WIDTH-1:0] output_data,
    output logic [15:0]           output_channel,
    output logic                  output_last,
    output logic                  output_valid,
    input  logic                  output_ready
);

    act_state_t            state, state_nxt;
    act_mode_t             mode_q;
    logic [3:0]            shift_q;
    logic [15:0]           nch_q, fsz_q;
    logic [15:0]           sample_cnt, channel_cnt;
    logic [DATA_WIDTH-1:0] act_y;
    logic                  last_elem;
    logic                  xfer;
    logic                  run_start;

    activation_func #(.DATA_WIDTH(DATA_WIDTH)) u_func (
        .x           (input_data),
        .mode        (mode_q),
        .leaky_shift (shift_q),
        .y           (act_y)
    );

    assign run_start   = (state == ST_IDLE) && start && !clear;
    assign last_elem   = (channel_cnt == nch_q - 16'd1) && (sample_cnt == fsz_q - 16'd1);
    assign input_ready = (state == ST_RUN) && !clear && (!output_valid || output_ready);
    assign xfer        = input_valid && input_ready;
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: clear dominates, empty runs skip straight to DONE
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start)
                        state_nxt = (num_channels == 16'd0 || feature_size == 16'd0) ? ST_DONE : ST_RUN;
                end
                ST_RUN: begin
                    if (xfer && last_elem) state_nxt = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (output_valid && output_ready) state_nxt = ST_DONE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Configuration latched once per run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= ACT_RELU;
            shift_q <= '0;
            nch_q   <= '0;
            fsz_q   <= '0;
        end else if (run_start) begin
            mode_q  <= act_mode_t'(mode);
            shift_q <= leaky_shift;
            nch_q   <= num_channels;
            fsz_q   <= feature_size;
        end
    end

    // Sample/channel position within the run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt  <= '0;
            channel_cnt <= '0;
        end else if (clear || run_start) begin
            sample_cnt  <= '0;
            channel_cnt <= '0;
        end else if (xfer) begin
            if (sample_cnt == fsz_q - 16'd1) begin
                sample_cnt  <= '0;
                channel_cnt <= channel_cnt + 16'd1;
            end else begin
                sample_cnt <= sample_cnt + 16'd1;
            end
        end
    end

    // Saturating zero counter; survives clear so the last figure stays readable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            zero_count <= '0;
        else if (run_start)
            zero_count <= '0;
        else if (xfer && act_y == '0 && zero_count != 32'hFFFF_FFFF)
            zero_count <= zero_count + 32'd1;
    end

    // Output register: loads on transfer, empties when downstream takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            output_valid   <= 1'b0;
            output_data    <= '0;
            output_channel <= '0;
            output_last    <= 1'b0;
        end else if (clear) begin
            output_valid <= 1'b0;
        end else if (xfer) begin
            output_valid   <= 1'b1;
            output_data    <= act_y;
            output_channel <= channel_cnt;
            output_last    <= last_elem;
        end else if (output_ready) begin
            output_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_activation_unit.sv
// tb/tb_activation_unit.sv - table-driven self-checking bench for activation_unit
module tb_activation_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, clear;
    logic [1:0]  mode;
    logic [3:0]  leaky_shift;
    logic [15:0] num_channels, feature_size;
    logic        busy, done;
    logic [31:0] zero_count;
    logic [15:0] input_data;
    logic        input_valid, input_ready;
    logic [15:0] output_data, output_channel;
    logic        output_last, output_valid, output_ready;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0]  mode;
        logic [3:0]  shift;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] ch;
        logic        last;
    } vec_t;

    vec_t vq[$];

    activation_unit #(.DATA_WIDTH(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .clear          (clear),
        .mode           (mode),
        .leaky_shift    (leaky_shift),
        .num_channels   (num_channels),
        .feature_size   (feature_size),
        .busy           (busy),
        .done           (done),
        .zero_count     (zero_count),
        .input_data     (input_data),
        .input_valid    (input_valid),
        .input_ready    (input_ready),
        .output_data    (output_data),
        .output_channel (output_channel),
        .output_last    (output_last),
        .output_valid   (output_valid),
        .output_ready   (output_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input logic [1:0] m, input logic [3:0] s,
                               input logic [15:0] nch, input logic [15:0] fsz);
        mode = m; leaky_shift = s; num_channels = nch; feature_size = fsz;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Stream table rows [first, first+n) at full rate and check each output and the done pulse
    task automatic run_vec(input int first, input int n, input logic [15:0] nch, input logic [15:0] fsz);
        int zeros = 0;
        output_ready = 1'b1;
        pulse_start(vq[first].mode, vq[first].shift, nch, fsz);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("ready_after_start", {31'd0, input_ready}, 32'd1);
        for (int i = first; i < first + n; i++) begin
            input_data  = vq[i].x;
            input_valid = 1'b1;
            @(negedge clk);
            check("out_valid", {31'd0, output_valid}, 32'd1);
            check($sformatf("out_data[%0d]", i), {16'd0, output_data}, {16'd0, vq[i].y});
            check($sformatf("out_ch[%0d]", i), {16'd0, output_channel}, {16'd0, vq[i].ch});
            check($sformatf("out_last[%0d]", i), {31'd0, output_last}, {31'd0, vq[i].last});
            if (vq[i].y == 16'h0000) zeros++;
        end
        check("ready_in_drain", {31'd0, input_ready}, 32'd0);
        input_valid = 1'b0;
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd1);
        check("busy_in_done", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("done_cleared", {31'd0, done}, 32'd0);
        check("busy_cleared", {31'd0, busy}, 32'd0);
        check("zero_count", zero_count, zeros);
    endtask

    initial begin
        logic [15:0] bp_x[4];
        logic [3:0]  rdy_pat;
        int          idx, got, k;
        logic        stalled_prev;
        logic [15:0] prev_data;
        logic        saw_ready, saw_valid;

        // ReLU 2x3
        vq.push_back('{2'b00, 4'd0, 16'h0100, 16'h0100, 16'd0, 1'b0});
        vq.push_back('{2'b00, 4'd0, 16'hFF00, 16'h0000, 16'd0, 1'b0});
        vq.push_back('{2'b00, 4'd0, 16'h0000, 16'h0000, 16'd0, 1'b0});
        vq.push_back('{2'b00, 4'd0, 16'h0280, 16'h0280, 16'd1, 1'b0});
        vq.push_back('{2'b00, 4'd0, 16'h8000, 16'h0000, 16'd1, 1'b0});
        vq.push_back('{2'b00, 4'd0, 16'h7FFF, 16'h7FFF, 16'd1, 1'b1});
        // ReLU6 1x4
        vq.push_back('{2'b01, 4'd0, 16'h0700, 16'h0600, 16'd0, 1'b0});
        vq.push_back('{2'b01, 4'd0, 16'h0600, 16'h0600, 16'd0, 1'b0});
        vq.push_back('{2'b01, 4'd0, 16'h05FF, 16'h05FF, 16'd0, 1'b0});
        vq.push_back('{2'b01, 4'd0, 16'hFFFF, 16'h0000, 16'd0, 1'b1});
        // Leaky shift 2, 1x3
        vq.push_back('{2'b10, 4'd2, 16'hFC00, 16'hFF00, 16'd0, 1'b0});
        vq.push_back('{2'b10, 4'd2, 16'hFFFF, 16'hFFFF, 16'd0, 1'b0});
        vq.push_back('{2'b10, 4'd2, 16'h0400, 16'h0400, 16'd0, 1'b1});
        // Identity 2x1
        vq.push_back('{2'b11, 4'd0, 16'h8000, 16'h8000, 16'd0, 1'b0});
        vq.push_back('{2'b11, 4'd0, 16'h0000, 16'h0000, 16'd1, 1'b1});

        rst_n = 1'b0; start = 1'b0; clear = 1'b0; mode = 2'b00; leaky_shift = 4'd0;
        num_channels = 16'd0; feature_size = 16'd0; input_data = 16'd0;
        input_valid = 1'b0; output_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ready", {31'd0, input_ready}, 32'd0);
        check("rst_valid", {31'd0, output_valid}, 32'd0);
        check("rst_data", {16'd0, output_data}, 32'd0);
        check("rst_ch", {16'd0, output_channel}, 32'd0);
        check("rst_last", {31'd0, output_last}, 32'd0);
        check("rst_zero", zero_count, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_vec(0, 6, 16'd2, 16'd3);
        run_vec(6, 4, 16'd1, 16'd4);
        run_vec(10, 3, 16'd1, 16'd3);
        run_vec(13, 2, 16'd2, 16'd1);

        // Backpressure: output_ready cycles 1,0,0,1 while input_valid stays high
        bp_x = '{16'h0111, 16'h0222, 16'h0333, 16'h0444};
        rdy_pat = 4'b1001;
        output_ready = 1'b1;
        pulse_start(2'b11, 4'd0, 16'd1, 16'd4);
        idx = 0; got = 0; k = 0; stalled_prev = 1'b0; prev_data = 16'd0;
        while (got < 4 && k < 40) begin
            output_ready = rdy_pat[3 - (k % 4)];
            input_valid  = (idx < 4);
            input_data   = (idx < 4) ? bp_x[idx] : 16'd0;
            #1;
            if (stalled_prev) begin
                check("bp_stable_valid", {31'd0, output_valid}, 32'd1);
                check("bp_stable_data", {16'd0, output_data}, {16'd0, prev_data});
            end
            if (output_valid && output_ready) begin
                check($sformatf("bp_out[%0d]", got), {16'd0, output_data}, {16'd0, bp_x[got]});
                got++;
            end
            stalled_prev = output_valid && !output_ready;
            prev_data    = output_data;
            if (input_valid && input_ready) idx++;
            @(negedge clk);
            k++;
        end
        check("bp_count", got, 32'd4);
        check("bp_done", {31'd0, done}, 32'd1);
        input_valid = 1'b0;
        output_ready = 1'b1;
        @(negedge clk);

        // Empty run goes straight to DONE without touching the stream
        saw_ready = input_ready; saw_valid = output_valid;
        pulse_start(2'b00, 4'd0, 16'd0, 16'd5);
        check("empty_done", {31'd0, done}, 32'd1);
        saw_ready |= input_ready; saw_valid |= output_valid;
        @(negedge clk);
        check("empty_done_clr", {31'd0, done}, 32'd0);
        check("empty_busy", {31'd0, busy}, 32'd0);
        saw_ready |= input_ready; saw_valid |= output_valid;
        check("empty_no_ready", {31'd0, saw_ready}, 32'd0);
        check("empty_no_valid", {31'd0, saw_valid}, 32'd0);

        // Clear after two of six elements, then a clean run
        pulse_start(2'b00, 4'd0, 16'd2, 16'd3);
        input_valid = 1'b1;
        input_data = 16'h0000;
        @(negedge clk);
        input_data = 16'h0100;
        @(negedge clk);
        check("pre_clear_zero", zero_count, 32'd1);
        input_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_valid", {31'd0, output_valid}, 32'd0);
        check("clr_ready", {31'd0, input_ready}, 32'd0);
        check("clr_busy", {31'd0, busy}, 32'd0);
        check("clr_zero_hold", zero_count, 32'd1);
        saw_valid = done;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            saw_valid |= done;
        end
        check("clr_no_done", {31'd0, saw_valid}, 32'd0);
        run_vec(0, 6, 16'd2, 16'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
